// File: rtl/uart.sv
// 8N1 UART with programmable baud divisor, single-byte TX/RX holding registers
// and level IRQ outputs, on the shared 8-bit host bus.
module uart #(
    parameter logic [7:0] DEFAULT_DIV = 8'd12
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire  [7:0]  D,
    input  logic [13:0] A,
    input  logic        cs,
    input  logic        re,
    input  logic        we,
    input  logic        rxd,
    output logic        txd,
    output logic        uart_rx_irq,
    output logic        uart_tx_irq
);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [DATA_W-1:0] div_q, tick_cnt, rx_data, tx_hold, rd_mux;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W+1:0] tx_sh;
    logic              tick, rx_ie, tx_ie;
    logic              wr_q, wr_stb, bus_rd, rd_pend, rx_clr;
    logic              wr_data, wr_stat, wr_ctrl, wr_div;
    logic              rxd_p0, rxd_p1;
    rx_state_t         rx_state;
    logic [3:0]        rx_tcnt, tx_tcnt, tx_bcnt;
    logic [2:0]        rx_bcnt;
    logic              rx_done, rx_stop, rx_full, ovr, fe;
    logic              tx_empty, tx_busy, tx_bit_end, tx_load, tx_shift;
    logic              unused_addr;

    assign unused_addr = ^A[13:2];
    assign bus_rd  = cs && re;
    assign wr_stb  = cs && we && !wr_q;
    assign wr_data = wr_stb && (A[1:0] == 2'd0);
    assign wr_stat = wr_stb && (A[1:0] == 2'd1);
    assign wr_ctrl = wr_stb && (A[1:0] == 2'd2);
    assign wr_div  = wr_stb && (A[1:0] == 2'd3);
    // rx_full is released once the data read strobe goes away, not while it is held
    assign rx_clr  = rd_pend && !bus_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            rd_pend <= 1'b0;
            div_q   <= DEFAULT_DIV;
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
        end else begin
            wr_q <= cs && we;
            if (bus_rd && (A[1:0] == 2'd0))
                rd_pend <= 1'b1;
            else if (!bus_rd)
                rd_pend <= 1'b0;
            if (wr_div)
                div_q <= D;
            if (wr_ctrl) begin
                tx_ie <= D[1];
                rx_ie <= D[0];
            end
        end
    end

    // 16x oversample tick
    assign tick = (tick_cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= DEFAULT_DIV;
        else if (wr_div)
            tick_cnt <= D;
        else if (tick)
            tick_cnt <= div_q;
        else
            tick_cnt <= tick_cnt - 8'd1;
    end

    // rxd synchroniser, p0 -> p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= 4'd0;
            rx_bcnt  <= 3'd0;
            rx_done  <= 1'b0;
            rx_stop  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_p1) begin
                        rx_state <= RX_START;
                        rx_tcnt  <= 4'd0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt  <= 4'd0;
                            rx_bcnt  <= 3'd0;
                            rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_bcnt <= rx_bcnt + 3'd1;
                            if (rx_bcnt == 3'd7)
                                rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_done  <= 1'b1;
                            rx_stop  <= rxd_p1;
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && tick && rx_tcnt == 4'd15)
            rx_sh <= {rxd_p1, rx_sh[DATA_W-1:1]};
        if (rx_done && rx_stop && !(rx_full && !rx_clr))
            rx_data <= rx_sh;
    end

    // RX flags, one edge after the stop sample; read-clear first, then sets win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full <= 1'b0;
            ovr     <= 1'b0;
            fe      <= 1'b0;
        end else begin
            if (rx_clr)
                rx_full <= 1'b0;
            if (wr_stat) begin
                ovr <= 1'b0;
                fe  <= 1'b0;
            end
            if (rx_done) begin
                if (!rx_stop)
                    fe <= 1'b1;
                else if (rx_full && !rx_clr)
                    ovr <= 1'b1;
                else
                    rx_full <= 1'b1;
            end
        end
    end

    assign tx_bit_end = tx_busy && tick && (tx_tcnt == 4'd15);
    assign tx_load    = !tx_empty && (!tx_busy || (tx_bit_end && tx_bcnt == 4'd9));
    assign tx_shift   = tx_bit_end && (tx_bcnt != 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_empty <= 1'b1;
            tx_busy  <= 1'b0;
            txd      <= 1'b1;
            tx_tcnt  <= 4'd0;
            tx_bcnt  <= 4'd0;
        end else begin
            if (wr_data && tx_empty)
                tx_empty <= 1'b0;
            if (tx_load) begin
                tx_empty <= 1'b1;
                tx_busy  <= 1'b1;
                txd      <= 1'b0;
                tx_tcnt  <= 4'd0;
                tx_bcnt  <= 4'd0;
            end else if (tx_busy && tick) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_tcnt == 4'd15) begin
                    if (tx_bcnt == 4'd9) begin
                        tx_busy <= 1'b0;
                        txd     <= 1'b1;
                    end else begin
                        tx_bcnt <= tx_bcnt + 4'd1;
                        txd     <= tx_sh[1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_data && tx_empty)
            tx_hold <= D;
        if (tx_load)
            tx_sh <= {1'b1, tx_hold, 1'b0};
        else if (tx_shift)
            tx_sh <= {1'b1, tx_sh[DATA_W+1:1]};
    end

    always_comb begin
        rd_mux = 8'h00;
        case (A[1:0])
            2'd0: rd_mux = rx_data;
            2'd1: rd_mux = {3'b000, tx_busy, fe, ovr, tx_empty, rx_full};
            2'd2: rd_mux = {6'b000000, tx_ie, rx_ie};
            default: rd_mux = div_q;
        endcase
    end

    assign D           = bus_rd ? rd_mux : 8'hzz;
    assign uart_rx_irq = rx_full && rx_ie;
    assign uart_tx_irq = tx_empty && tx_ie;
endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: reset, loopback, overrun, framing, false start,
// IRQs, held write strobe and back-to-back TX framing.
module tb_uart;
    logic        clk = 1'b0;
    logic        rst_n, cs, re, we;
    logic [13:0] A;
    logic        d_en;
    logic [7:0]  d_drv;
    wire  [7:0]  D;
    logic        rxd, rxd_drv, loop_en;
    logic        txd, uart_rx_irq, uart_tx_irq;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;

    assign D   = d_en ? d_drv : 8'hzz;
    assign rxd = loop_en ? txd : rxd_drv;

    uart #(.DEFAULT_DIV(8'd12)) dut (
        .clk(clk), .rst_n(rst_n), .D(D), .A(A), .cs(cs), .re(re), .we(we),
        .rxd(rxd), .txd(txd), .uart_rx_irq(uart_rx_irq), .uart_tx_irq(uart_tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        A = {12'd0, a}; d_drv = d; d_en = 1'b1; cs = 1'b1; we = 1'b1;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; d_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] q);
        @(negedge clk);
        A = {12'd0, a}; cs = 1'b1; re = 1'b1;
        #1 q = D;
        @(negedge clk);
        cs = 1'b0; re = 1'b0;
    endtask

    // drives one 8N1 frame at div=0 (16 clocks per bit)
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (16) @(negedge clk);
        end
        rxd_drv = stop;
        repeat (16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_rx_irq(input int max_c, output int n);
        n = 0;
        while (!uart_rx_irq && n < max_c) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] q;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (txd !== 1'b1) $display("FAIL txd_in_reset got %b want 1", txd); else pass_cnt++;
        total_cnt++;
        if ({uart_rx_irq, uart_tx_irq} !== 2'b00)
            $display("FAIL irq_in_reset got %b want 00", {uart_rx_irq, uart_tx_irq});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        bus_write(2'd3, 8'h00);
        bus_write(2'd2, 8'h03);
        bus_write(2'd0, 8'h00);
        repeat (40) @(negedge clk);
        total_cnt++;
        if (txd !== 1'b0) $display("FAIL txd_mid_frame got %b want 0", txd); else pass_cnt++;
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h12) $display("FAIL status_mid_frame got %h want 12", q); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (txd !== 1'b1) $display("FAIL txd_async_reset got %b want 1", txd); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL reset_status got %h want 02", q); else pass_cnt++;
        bus_read(2'd2, q);
        total_cnt++;
        if (q !== 8'h00) $display("FAIL reset_ctrl got %h want 00", q); else pass_cnt++;
        bus_read(2'd3, q);
        total_cnt++;
        if (q !== 8'h0C) $display("FAIL reset_div got %h want 0c", q); else pass_cnt++;
        total_cnt++;
        if (uart_tx_irq !== 1'b0) $display("FAIL reset_tx_irq got %b want 0", uart_tx_irq); else pass_cnt++;
    endtask

    task automatic test_held_write();
        logic [7:0] q;
        int t_e;
        bus_write(2'd3, 8'h00);
        @(negedge clk);
        A = 14'd0; d_drv = 8'h0F; d_en = 1'b1; cs = 1'b1; we = 1'b1;
        @(negedge clk);
        t_e = cyc;
        repeat (3) @(negedge clk);
        cs = 1'b0; we = 1'b0; d_en = 1'b0;
        while (cyc < t_e + 150) @(negedge clk);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h12) $display("FAIL held_write_busy got %h want 12", q); else pass_cnt++;
        while (cyc < t_e + 170) @(negedge clk);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL held_write_once got %h want 02", q); else pass_cnt++;
    endtask

    task automatic test_loopback();
        logic [7:0] q;
        int n;
        loop_en = 1'b1;
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'hA5);
        wait_rx_irq(300, n);
        total_cnt++;
        if (!(n >= 150 && n <= 170)) $display("FAIL loop_latency got %0d want 150..170", n);
        else pass_cnt++;
        repeat (10) @(negedge clk);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h03) $display("FAIL loop_status got %h want 03", q); else pass_cnt++;
        bus_read(2'd0, q);
        total_cnt++;
        if (q !== 8'hA5) $display("FAIL loop_data got %h want a5", q); else pass_cnt++;
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL loop_cleared got %h want 02", q); else pass_cnt++;
        bus_write(2'd2, 8'h00);
        loop_en = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] q;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h07) $display("FAIL ovr_status got %h want 07", q); else pass_cnt++;
        bus_write(2'd1, 8'h00);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h03) $display("FAIL ovr_cleared got %h want 03", q); else pass_cnt++;
        bus_read(2'd0, q);
        total_cnt++;
        if (q !== 8'h11) $display("FAIL ovr_keeps_old got %h want 11", q); else pass_cnt++;
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL ovr_after_read got %h want 02", q); else pass_cnt++;
    endtask

    task automatic test_framing();
        logic [7:0] q;
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h0A) $display("FAIL fe_status got %h want 0a", q); else pass_cnt++;
        bus_write(2'd1, 8'h00);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL fe_cleared got %h want 02", q); else pass_cnt++;
    endtask

    task automatic test_false_start();
        logic [7:0] q;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL glitch_status got %h want 02", q); else pass_cnt++;
        send_byte(8'h5A, 1'b1);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h03) $display("FAIL after_glitch_status got %h want 03", q); else pass_cnt++;
        bus_read(2'd0, q);
        total_cnt++;
        if (q !== 8'h5A) $display("FAIL after_glitch_data got %h want 5a", q); else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [7:0] q;
        int n;
        bus_write(2'd2, 8'h03);
        total_cnt++;
        if ({uart_rx_irq, uart_tx_irq} !== 2'b01)
            $display("FAIL irq_enable got %b want 01", {uart_rx_irq, uart_tx_irq});
        else pass_cnt++;
        loop_en = 1'b1;
        bus_write(2'd0, 8'h55);
        total_cnt++;
        if (uart_tx_irq !== 1'b0) $display("FAIL tx_irq_drop got %b want 0", uart_tx_irq); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (uart_tx_irq !== 1'b1) $display("FAIL tx_irq_reload got %b want 1", uart_tx_irq); else pass_cnt++;
        wait_rx_irq(300, n);
        total_cnt++;
        if (uart_rx_irq !== 1'b1) $display("FAIL rx_irq_rise got %b want 1 after %0d", uart_rx_irq, n);
        else pass_cnt++;
        bus_read(2'd0, q);
        total_cnt++;
        if (q !== 8'h55) $display("FAIL irq_rx_data got %h want 55", q); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (uart_rx_irq !== 1'b0) $display("FAIL rx_irq_drop got %b want 0", uart_rx_irq); else pass_cnt++;
        loop_en = 1'b0;
        repeat (20) @(negedge clk);
        bus_write(2'd2, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q;
        logic [19:0] exp_bits;
        int t0, n;
        exp_bits = {1'b1, 8'h7E, 1'b0, 1'b1, 8'h81, 1'b0};
        bus_write(2'd0, 8'h81);
        n = 0;
        while (txd !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        total_cnt++;
        if (txd !== 1'b0) $display("FAIL b2b_start got %b want 0", txd); else pass_cnt++;
        bus_write(2'd0, 8'h7E);
        for (int b = 0; b < 20; b++) begin
            while (cyc < t0 + 8 + 16 * b) @(negedge clk);
            total_cnt++;
            if (txd !== exp_bits[b]) $display("FAIL b2b_bit%0d got %b want %b", b, txd, exp_bits[b]);
            else pass_cnt++;
        end
        while (cyc < t0 + 330) @(negedge clk);
        bus_read(2'd1, q);
        total_cnt++;
        if (q !== 8'h02) $display("FAIL b2b_idle got %h want 02", q); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; re = 1'b0; we = 1'b0; A = 14'd0;
        d_en = 1'b0; d_drv = 8'h00; rxd_drv = 1'b1; loop_en = 1'b0;
        test_reset();
        test_held_write();
        test_loopback();
        test_overrun();
        test_framing();
        test_false_start();
        test_irq();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
